// File: rtl/CoreMod_IoArb_pkg.sv
// CoreMod_IoArb_pkg: shared state, payload and helper definitions for the IO bus arbiter.
package CoreMod_IoArb_pkg;

  // Payload storage is sized for the core's data bus (DCache/MMU port).
  localparam int IO_ADDR_W = 40;
  localparam int IO_DATA_W = 64;

  localparam logic [1:0] IO_SIZE_B = 2'd0;
  localparam logic [1:0] IO_SIZE_H = 2'd1;
  localparam logic [1:0] IO_SIZE_W = 2'd2;
  localparam logic [1:0] IO_SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } io_arb_state_t;

  typedef struct packed {
    logic                 wr;
    logic [1:0]           size;
    logic [IO_ADDR_W-1:0] addr;
    logic [IO_DATA_W-1:0] wdata;
  } io_req_t;

  function automatic int rrNext(int idx, int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/io_arb_rr_picker.sv
// io_arb_rr_picker: urgent-first picker; ties go to the first index at or after ptr, wrapping.
module io_arb_rr_picker #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  cand,
  input  logic [N-1:0]  urgent,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          anyCand
);

  logic [N-1:0]  pool;
  logic [IW-1:0] hiIdx;
  logic [IW-1:0] loIdx;
  logic          hiHit;

  assign pool    = |(cand & urgent) ? (cand & urgent) : cand;
  assign anyCand = |pool;

  // Scan downwards so the last hit is the lowest index overall (loIdx) and at/after ptr (hiIdx).
  always_comb begin
    hiHit = 1'b0;
    hiIdx = '0;
    loIdx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pool[i]) loIdx = IW'(i);
      if (pool[i] && IW'(i) >= ptr) begin
        hiHit = 1'b1;
        hiIdx = IW'(i);
      end
    end
    index  = hiHit ? hiIdx : loIdx;
    onehot = anyCand ? (N'(1) << index) : '0;
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the core's single data IO bus between NUM_REQ requesters,
// urgent-first round-robin, with locked sequences, per-requester flush and a watchdog.
module io_bus_arbiter
  import CoreMod_IoArb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 40,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_urgent,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ-1:0]           req_wr,
  input  logic [NUM_REQ*2-1:0]         req_size,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           flush,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         bus_valid,
  input  logic                         bus_ready,
  output logic                         bus_wr,
  output logic [1:0]                   bus_size,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [DATA_W-1:0]            bus_wdata,
  input  logic                         bus_rsp_valid,
  input  logic [DATA_W-1:0]            bus_rdata,
  input  logic                         bus_err,
  output logic                         bus_abort,
  output logic [$clog2(NUM_REQ)-1:0]   owner,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_REQ);

  io_arb_state_t      state;
  io_arb_state_t      nextState;
  io_req_t            payload;
  logic [IW-1:0]      ownerQ;
  logic [IW-1:0]      rrPtr;
  logic [IW-1:0]      winIdx;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] winOh;
  logic [NUM_REQ-1:0] ownerOh;
  logic               anyCand;
  logic               lockValid;
  logic               lockPending;
  logic               flushed;
  logic [15:0]        wdCnt;
  logic [DATA_W-1:0]  rspRdataQ;
  logic               rspErrQ;
  logic               accept;
  logic               ownerFlush;
  logic               issueFlush;
  logic               rspDone;
  logic               timeout;
  logic               rspFire;

  assign ownerOh    = NUM_REQ'(1) << ownerQ;
  assign ownerFlush = flush[ownerQ];
  assign cand       = req_valid & ~flush & (lockValid ? ownerOh : '1);

  io_arb_rr_picker #(
    .N (NUM_REQ),
    .IW(IW)
  ) picker (
    .cand   (cand),
    .urgent (req_urgent),
    .ptr    (rrPtr),
    .onehot (winOh),
    .index  (winIdx),
    .anyCand(anyCand)
  );

  assign accept     = (state == IDLE) && anyCand;
  assign issueFlush = (state == ISSUE) && ownerFlush;
  assign rspDone    = (state == WAIT) && bus_rsp_valid;
  // A completion or an ISSUE-time flush on the last watchdog cycle wins over the abort.
  assign timeout    = (state != IDLE) && (wdCnt == 16'(TIMEOUT - 1)) && !rspDone && !issueFlush;
  assign rspFire    = (rspDone || timeout) && !(flushed || ownerFlush);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nextState;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = anyCand ? ISSUE : IDLE;
      ISSUE:   nextState = (issueFlush || timeout) ? IDLE : (bus_ready ? WAIT : ISSUE);
      WAIT:    nextState = (rspDone || timeout) ? IDLE : WAIT;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? winOh : '0;
    bus_valid = (state == ISSUE) && !issueFlush;
    bus_abort = timeout;
    rsp_valid = rspFire ? ownerOh : '0;
    rsp_rdata = (rspFire && rspDone) ? bus_rdata : rspRdataQ;
    rsp_err   = rspFire ? (rspDone ? bus_err : 1'b1) : rspErrQ;
    busy      = state != IDLE;
  end

  assign bus_wr    = payload.wr;
  assign bus_size  = payload.size;
  assign bus_addr  = ADDR_W'(payload.addr);
  assign bus_wdata = DATA_W'(payload.wdata);
  assign owner     = ownerQ;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      payload     <= '0;
      ownerQ      <= '0;
      rrPtr       <= '0;
      lockValid   <= 1'b0;
      lockPending <= 1'b0;
      flushed     <= 1'b0;
      wdCnt       <= '0;
      rspRdataQ   <= '0;
      rspErrQ     <= 1'b0;
    end else begin
      if (accept) begin
        payload.wr    <= req_wr[winIdx];
        payload.size  <= req_size[winIdx*2 +: 2];
        payload.addr  <= IO_ADDR_W'(req_addr[winIdx*ADDR_W +: ADDR_W]);
        payload.wdata <= IO_DATA_W'(req_wdata[winIdx*DATA_W +: DATA_W]);
        ownerQ        <= winIdx;
        rrPtr         <= IW'(rrNext(int'(winIdx), NUM_REQ));
        lockPending   <= req_lock[winIdx];
        flushed       <= 1'b0;
        wdCnt         <= '0;
      end else if (state != IDLE) wdCnt <= wdCnt + 16'd1;
      if (state == WAIT && ownerFlush) flushed <= 1'b1;
      if (rspFire) begin
        rspRdataQ <= rsp_rdata;
        rspErrQ   <= rsp_err;
      end
      // A flush by the lock holder while idle also drops its lock.
      if (issueFlush || timeout || (state == IDLE && lockValid && ownerFlush)) lockValid <= 1'b0;
      else if (rspDone) lockValid <= lockPending && !bus_err && !(flushed || ownerFlush);
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: randomized self-checking bench; the model predicts grants from
// the round-robin pointer (last grantee + 1) and urgent-first rule, plus lock/flush/watchdog outcomes.
module tb_io_bus_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid, req_urgent, req_lock, req_wr, req_ready, flush, rsp_valid;
  logic [3:0]  req_size;
  logic [79:0] req_addr;
  logic [127:0] req_wdata;
  logic [63:0] rsp_rdata, bus_wdata, bus_rdata;
  logic        rsp_err, bus_valid, bus_ready, bus_wr, bus_rsp_valid, bus_err, bus_abort, busy;
  logic [1:0]  bus_size;
  logic [39:0] bus_addr;
  logic        owner;

  int nCmp = 0;
  int nBad = 0;
  int mRr = 0;
  logic [39:0] mAddr [2];
  logic [63:0] mData [2];

  always #5 clk = ~clk;

  io_bus_arbiter #(.NUM_REQ(2), .ADDR_W(40), .DATA_W(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_urgent(req_urgent), .req_lock(req_lock), .req_wr(req_wr),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata(bus_rdata), .bus_err(bus_err), .bus_abort(bus_abort), .owner(owner), .busy(busy)
  );

  // Urgent requesters form the pool if any exist; the pointer's requester wins a tie.
  function automatic int pick(logic [1:0] v, logic [1:0] u, int rr);
    logic [1:0] p;
    p = ((v & u) != 2'b00) ? (v & u) : v;
    if (p == 2'b00) return -1;
    return p[rr] ? rr : 1 - rr;
  endfunction

  task automatic newPayload();
    for (int i = 0; i < 2; i++) begin
      mAddr[i] = 40'({$urandom(), $urandom()});
      mData[i] = {$urandom(), $urandom()};
    end
    req_addr  = {mAddr[1], mAddr[0]};
    req_wdata = {mData[1], mData[0]};
    req_wr    = 2'($urandom_range(0, 3));
    req_size  = 4'($urandom_range(0, 15));
  endtask

  // Called at a negedge in IDLE with requests applied; returns what the DUT showed.
  task automatic runTxn(input int rdyDly, input int rspDly, input logic [63:0] rd, input logic er,
                        output logic [1:0] gotReady, output logic [39:0] gotAddr,
                        output logic [63:0] gotWdata, output logic [1:0] gotRsp,
                        output logic [63:0] gotRdata, output logic gotErr);
    #1 gotReady = req_ready;
    @(negedge clk);
    gotAddr  = bus_addr;
    gotWdata = bus_wdata;
    repeat (rdyDly) @(negedge clk);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    repeat (rspDly) @(negedge clk);
    bus_rsp_valid = 1'b1;
    bus_rdata     = rd;
    bus_err       = er;
    #1 gotRsp = rsp_valid;
    gotRdata = rsp_rdata;
    gotErr   = rsp_err;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    bus_err       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    nCmp++;
    if ({busy, bus_valid, bus_abort, rsp_valid, req_ready, owner, bus_addr, rsp_rdata, rsp_err} !== '0) begin
      nBad++;
      $display("FAIL reset_outputs: got busy=%b bv=%b abort=%b rv=%b rdy=%b own=%b addr=%h, want all 0",
               busy, bus_valid, bus_abort, rsp_valid, req_ready, owner, bus_addr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    newPayload();
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    #1 nCmp++;
    if (busy !== 1'b1) begin nBad++; $display("FAIL wait_busy: got %b want 1", busy); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mRr = 0;
    #1 nCmp++;
    if ({busy, bus_valid, rsp_valid, owner} !== 5'b0) begin
      nBad++;
      $display("FAIL reset_mid_wait: got busy=%b bv=%b rv=%b own=%b want 0", busy, bus_valid, rsp_valid, owner);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [1:0] rdy, rv;
    logic [39:0] a;
    logic [63:0] wd, rd;
    logic er;
    int w;
    req_valid = 2'b11;
    req_urgent = 2'b00;
    for (int i = 0; i < 3; i++) begin
      newPayload();
      w = pick(2'b11, 2'b00, mRr);
      runTxn(i, 2 - i, 64'hDEAD_BEEF_0000_0001, 1'b0, rdy, a, wd, rv, rd, er);
      nCmp += 4;
      if (rdy !== 2'(1 << w)) begin nBad++; $display("FAIL rr_ready[%0d]: got %b want %b", i, rdy, 2'(1 << w)); end
      if (a !== mAddr[w]) begin nBad++; $display("FAIL rr_addr[%0d]: got %h want %h", i, a, mAddr[w]); end
      if (rv !== 2'(1 << w)) begin nBad++; $display("FAIL rr_rsp[%0d]: got %b want %b", i, rv, 2'(1 << w)); end
      if ({rd, er} !== {64'hDEAD_BEEF_0000_0001, 1'b0}) begin nBad++; $display("FAIL rr_rdata[%0d]: got %h/%b want deadbeef00000001/0", i, rd, er); end
      mRr = 1 - w;
    end
    req_valid = 2'b00;
  endtask

  task automatic test_urgent();
    logic [1:0] rdy, rv;
    logic [39:0] a;
    logic [63:0] wd, rd;
    logic er;
    logic [1:0] urg [3] = '{2'b10, 2'b01, 2'b11};
    int w;
    req_valid = 2'b10;
    newPayload();
    runTxn(0, 0, 64'h1, 1'b0, rdy, a, wd, rv, rd, er);
    mRr = 0;
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_urgent = urg[i];
      newPayload();
      w = pick(2'b11, urg[i], mRr);
      runTxn(1, 0, 64'h2, 1'b0, rdy, a, wd, rv, rd, er);
      nCmp += 2;
      if (rdy !== 2'(1 << w)) begin nBad++; $display("FAIL urgent_ready[%0d]: got %b want %b", i, rdy, 2'(1 << w)); end
      if (rv !== 2'(1 << w)) begin nBad++; $display("FAIL urgent_rsp[%0d]: got %b want %b", i, rv, 2'(1 << w)); end
      mRr = 1 - w;
    end
    req_valid = 2'b00;
    req_urgent = 2'b00;
  endtask

  task automatic test_lock();
    logic [1:0] rdy, rv;
    logic [39:0] a;
    logic [63:0] wd, rd;
    logic er;
    req_valid = 2'b01;
    req_lock = 2'b01;
    newPayload();
    runTxn(0, 1, 64'h3, 1'b0, rdy, a, wd, rv, rd, er);
    nCmp++;
    if (rv !== 2'b01) begin nBad++; $display("FAIL lock_first_rsp: got %b want 01", rv); end
    req_valid = 2'b10;
    req_urgent = 2'b10;
    req_lock = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1 nCmp++;
      if ({req_ready, busy} !== 3'b000) begin nBad++; $display("FAIL lock_starve[%0d]: got rdy=%b busy=%b want 00/0", i, req_ready, busy); end
      @(negedge clk);
    end
    req_valid = 2'b11;
    runTxn(0, 0, 64'h4, 1'b0, rdy, a, wd, rv, rd, er);
    nCmp++;
    if ({rdy, rv} !== 4'b0101) begin nBad++; $display("FAIL lock_release: got rdy=%b rv=%b want 01/01", rdy, rv); end
    req_valid = 2'b10;
    runTxn(0, 0, 64'h5, 1'b0, rdy, a, wd, rv, rd, er);
    nCmp++;
    if ({rdy, rv} !== 4'b1010) begin nBad++; $display("FAIL lock_after: got rdy=%b rv=%b want 10/10", rdy, rv); end
    req_valid = 2'b01;
    req_lock = 2'b01;
    req_urgent = 2'b00;
    runTxn(0, 0, 64'h6, 1'b1, rdy, a, wd, rv, rd, er);
    req_valid = 2'b10;
    req_lock = 2'b00;
    #1 nCmp++;
    if (req_ready !== 2'b10) begin nBad++; $display("FAIL lock_err_drop: got %b want 10", req_ready); end
    runTxn(0, 0, 64'h7, 1'b0, rdy, a, wd, rv, rd, er);
    mRr = 0;
    req_valid = 2'b00;
  endtask

  task automatic test_watchdog();
    req_valid = 2'b01;
    req_lock = 2'b01;
    bus_ready = 1'b0;
    #1 nCmp++;
    if (req_ready !== 2'b01) begin nBad++; $display("FAIL wd_ready: got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    req_lock = 2'b00;
    for (int c = 1; c <= TO; c++) begin
      #1 nCmp++;
      if ({bus_abort, rsp_valid} !== ((c == TO) ? 3'b101 : 3'b000)) begin
        nBad++;
        $display("FAIL wd_cycle[%0d]: got abort=%b rv=%b want %b/%b", c, bus_abort, rsp_valid, c == TO, (c == TO) ? 2'b01 : 2'b00);
      end
      if (c == TO) begin
        nCmp++;
        if (rsp_err !== 1'b1) begin nBad++; $display("FAIL wd_err: got %b want 1", rsp_err); end
      end
      @(negedge clk);
    end
    #1 nCmp++;
    if (busy !== 1'b0) begin nBad++; $display("FAIL wd_idle: got busy=%b want 0", busy); end
    mRr = 1;
    req_valid = 2'b10;
    #1 nCmp++;
    if (req_ready !== 2'b10) begin nBad++; $display("FAIL wd_lock_drop: got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    mRr = 0;
    repeat (2) @(negedge clk);
    flush = 2'b10;
    #1 nCmp++;
    if ({rsp_valid, bus_abort, bus_valid} !== 4'b0000) begin
      nBad++;
      $display("FAIL issue_flush: got rv=%b abort=%b bv=%b want 00/0/0", rsp_valid, bus_abort, bus_valid);
    end
    @(negedge clk);
    flush = 2'b00;
    #1 nCmp++;
    if (busy !== 1'b0) begin nBad++; $display("FAIL issue_flush_idle: got busy=%b want 0", busy); end
    for (int i = 0; i < TO + 2; i++) begin
      nCmp++;
      if ({rsp_valid, bus_abort} !== 3'b000) begin nBad++; $display("FAIL issue_flush_quiet[%0d]: got rv=%b abort=%b want 00/0", i, rsp_valid, bus_abort); end
      @(negedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  task automatic test_flush_wait();
    logic [1:0] rdy, rv;
    logic [39:0] a;
    logic [63:0] wd, rd;
    logic er;
    int w, w2;
    req_valid = 2'b11;
    newPayload();
    w = pick(2'b11, 2'b00, mRr);
    #1 nCmp++;
    if (req_ready !== 2'(1 << w)) begin nBad++; $display("FAIL fw_ready: got %b want %b", req_ready, 2'(1 << w)); end
    @(negedge clk);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    flush = 2'(1 << w);
    #1 nCmp++;
    if (rsp_valid !== 2'b00) begin nBad++; $display("FAIL fw_flush_cycle: got %b want 00", rsp_valid); end
    @(negedge clk);
    flush = 2'b00;
    for (int i = 0; i < 3; i++) begin
      #1 nCmp++;
      if ({rsp_valid, busy} !== 3'b001) begin nBad++; $display("FAIL fw_wait[%0d]: got rv=%b busy=%b want 00/1", i, rsp_valid, busy); end
      @(negedge clk);
    end
    bus_rsp_valid = 1'b1;
    bus_rdata = {$urandom(), $urandom()};
    #1 nCmp++;
    if (rsp_valid !== 2'b00) begin nBad++; $display("FAIL fw_rsp_suppressed: got %b want 00", rsp_valid); end
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    mRr = 1 - w;
    #1 nCmp++;
    if ({busy, req_ready} !== {1'b0, 2'(1 << (1 - w))}) begin
      nBad++;
      $display("FAIL fw_next_grant: got busy=%b rdy=%b want 0/%b", busy, req_ready, 2'(1 << (1 - w)));
    end
    runTxn(0, 0, 64'h8, 1'b0, rdy, a, wd, rv, rd, er);
    nCmp++;
    if (rv !== 2'(1 << (1 - w))) begin nBad++; $display("FAIL fw_other_rsp: got %b want %b", rv, 2'(1 << (1 - w))); end
    mRr = w;
    w2 = pick(2'b11, 2'b00, mRr);
    @(negedge clk);
    bus_ready = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    bus_ready = 1'b0;
    flush = 2'(1 << w2);
    bus_rsp_valid = 1'b1;
    #1 nCmp++;
    if (rsp_valid !== 2'b00) begin nBad++; $display("FAIL fw_same_cycle: got %b want 00", rsp_valid); end
    @(negedge clk);
    flush = 2'b00;
    bus_rsp_valid = 1'b0;
    mRr = 1 - w2;
    #1 nCmp++;
    if (busy !== 1'b0) begin nBad++; $display("FAIL fw_same_idle: got busy=%b want 0", busy); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0] rdy, rv, v, u;
    logic [39:0] a;
    logic [63:0] wd, rd, expRd;
    logic er, expEr;
    int w;
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      u = 2'($urandom_range(0, 3));
      req_valid = v;
      req_urgent = u;
      req_lock = 2'b00;
      newPayload();
      expRd = {$urandom(), $urandom()};
      expEr = ($urandom_range(0, 3) == 0);
      w = pick(v, u, mRr);
      runTxn($urandom_range(0, 3), $urandom_range(0, 3), expRd, expEr, rdy, a, wd, rv, rd, er);
      nCmp += 5;
      if (rdy !== 2'(1 << w)) begin nBad++; $display("FAIL rand_ready[%0d]: got %b want %b (v=%b u=%b)", i, rdy, 2'(1 << w), v, u); end
      if (a !== mAddr[w]) begin nBad++; $display("FAIL rand_addr[%0d]: got %h want %h", i, a, mAddr[w]); end
      if (wd !== mData[w]) begin nBad++; $display("FAIL rand_wdata[%0d]: got %h want %h", i, wd, mData[w]); end
      if (rv !== 2'(1 << w)) begin nBad++; $display("FAIL rand_rsp[%0d]: got %b want %b", i, rv, 2'(1 << w)); end
      if ({rd, er} !== {expRd, expEr}) begin nBad++; $display("FAIL rand_rdata[%0d]: got %h/%b want %h/%b", i, rd, er, expRd, expEr); end
      mRr = 1 - w;
      req_valid = 2'b00;
      req_urgent = 2'b00;
    end
  endtask

  initial begin
    req_valid = '0; req_urgent = '0; req_lock = '0; req_wr = '0; req_size = '0;
    req_addr = '0; req_wdata = '0; flush = '0;
    bus_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_reset_mid_wait();
    test_round_robin();
    test_urgent();
    test_lock();
    test_watchdog();
    test_flush_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1, "bench timeout");
  end

endmodule
